// File: rtl/snake_food_sched.sv
// Food-placement scheduler for Snake: draws X/Y candidates from an 8-bit Galois LFSR,
//   range-rejects them, checks occupancy over a valid/done handshake, then reports a free cell or a fail.
// Latency: req -> chk_valid after 3 edges best case, food_valid one edge after chk_done.
// Backpressure: chk_valid holds with stable chk_x/chk_y until chk_done; req is ignored while busy.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   seed_load/seed_in  reseed the LFSR (0x00 is replaced by 0xFF); has priority over the advance
//   req / busy         new-food request (taken only in IDLE) / scheduler active
//   chk_valid/x/y      candidate cell presented to the body-occupancy logic
//   chk_done/chk_hit   occupancy answer and its result (1 = occupied)
//   food_valid/x/y     one-cycle pulse with the accepted free cell; x/y hold the last accepted cell
//   fail               one-cycle pulse when MAX_TRIES occupied candidates were seen
//   rand_o             current LFSR state
module snake_food_sched #(
  parameter int GRID_W    = 40,
  parameter int GRID_H    = 30,
  parameter int X_W       = 6,
  parameter int Y_W       = 5,
  parameter int MAX_TRIES = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           seed_load,
  input  logic [7:0]     seed_in,
  input  logic           req,
  output logic           busy,
  output logic           chk_valid,
  output logic [X_W-1:0] chk_x,
  output logic [Y_W-1:0] chk_y,
  input  logic           chk_done,
  input  logic           chk_hit,
  output logic           food_valid,
  output logic [X_W-1:0] food_x,
  output logic [Y_W-1:0] food_y,
  output logic           fail,
  output logic [7:0]     rand_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRAW_X = 2'd1,
    S_DRAW_Y = 2'd2,
    S_CHECK  = 2'd3
  } state_t;

  // Compare in 9 bits so GRID_W/GRID_H == 256 is representable.
  localparam logic [8:0] GRID_W_L = 9'(GRID_W);
  localparam logic [8:0] GRID_H_L = 9'(GRID_H);
  localparam logic [7:0] TRY_LAST = 8'(MAX_TRIES - 1);

  state_t         state_q;
  logic [7:0]     lfsr_q;
  logic [7:0]     lfsr_d;
  logic [7:0]     try_q;
  logic           busy_q;
  logic           chk_valid_q;
  logic [X_W-1:0] chk_x_q;
  logic [Y_W-1:0] chk_y_q;
  logic           food_valid_q;
  logic [X_W-1:0] food_x_q;
  logic [Y_W-1:0] food_y_q;
  logic           fail_q;

  logic [X_W-1:0] cand_x;
  logic [Y_W-1:0] cand_y;
  logic           x_ok;
  logic           y_ok;

  // Next LFSR value: reseed wins over the free-running advance; a zero seed would lock up.
  always_comb begin
    lfsr_d = {lfsr_q[6:5], lfsr_q[4], lfsr_q[3] ^ lfsr_q[7], lfsr_q[2] ^ lfsr_q[7],
              lfsr_q[1] ^ lfsr_q[7], lfsr_q[0], lfsr_q[7]};
    if (seed_load) begin
      lfsr_d = (seed_in == 8'h00) ? 8'hFF : seed_in;
    end
  end

  // X comes from the low bits, Y from the high bits, so consecutive draws are less correlated.
  always_comb begin
    cand_x = lfsr_q[X_W-1:0];
    cand_y = lfsr_q[7:8-Y_W];
    x_ok   = 9'(cand_x) < GRID_W_L;
    y_ok   = 9'(cand_y) < GRID_H_L;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      lfsr_q       <= 8'hFF;
      try_q        <= '0;
      busy_q       <= 1'b0;
      chk_valid_q  <= 1'b0;
      chk_x_q      <= '0;
      chk_y_q      <= '0;
      food_valid_q <= 1'b0;
      food_x_q     <= '0;
      food_y_q     <= '0;
      fail_q       <= 1'b0;
    end else begin
      lfsr_q       <= lfsr_d;
      food_valid_q <= 1'b0;
      fail_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            state_q <= S_DRAW_X;
            try_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_DRAW_X: begin
          // Out-of-range draws simply wait for the next LFSR value; they cost no tries.
          if (x_ok) begin
            chk_x_q <= cand_x;
            state_q <= S_DRAW_Y;
          end
        end
        S_DRAW_Y: begin
          if (y_ok) begin
            chk_y_q     <= cand_y;
            chk_valid_q <= 1'b1;
            state_q     <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (chk_done) begin
            chk_valid_q <= 1'b0;
            try_q       <= try_q + 8'd1;
            if (!chk_hit) begin
              food_x_q     <= chk_x_q;
              food_y_q     <= chk_y_q;
              food_valid_q <= 1'b1;
              state_q      <= S_IDLE;
              busy_q       <= 1'b0;
            end else if (try_q == TRY_LAST) begin
              fail_q  <= 1'b1;
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_DRAW_X;
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          chk_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign chk_valid  = chk_valid_q;
  assign chk_x      = chk_x_q;
  assign chk_y      = chk_y_q;
  assign food_valid = food_valid_q;
  assign food_x     = food_x_q;
  assign food_y     = food_y_q;
  assign fail       = fail_q;
  assign rand_o     = lfsr_q;

endmodule

// File: tb/tb_snake_food_sched.sv
module tb_snake_food_sched;
  localparam int GW = 40;
  localparam int GH = 30;
  localparam int XW = 6;
  localparam int YW = 5;
  localparam int MT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          seed_load = 1'b0;
  logic [7:0]    seed_in = 8'h00;
  logic          req = 1'b0;
  logic          busy;
  logic          chk_valid;
  logic [XW-1:0] chk_x;
  logic [YW-1:0] chk_y;
  logic          chk_done = 1'b0;
  logic          chk_hit = 1'b0;
  logic          food_valid;
  logic [XW-1:0] food_x;
  logic [YW-1:0] food_y;
  logic          fail;
  logic [7:0]    rand_o;

  snake_food_sched #(
    .GRID_W(GW), .GRID_H(GH), .X_W(XW), .Y_W(YW), .MAX_TRIES(MT)
  ) dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in), .req(req),
    .busy(busy), .chk_valid(chk_valid), .chk_x(chk_x), .chk_y(chk_y),
    .chk_done(chk_done), .chk_hit(chk_hit), .food_valid(food_valid),
    .food_x(food_x), .food_y(food_y), .fail(fail), .rand_o(rand_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_food = 0;
  int n_fail = 0;
  int n_txn = 0;
  bit prev_cv = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  // Phase of the request in flight: 0 idle, 1 choosing column, 2 choosing row, 3 awaiting answer.
  int m_lfsr = 255;
  int m_phase = 0;
  int m_cx = 0, m_cy = 0, m_fx = 0, m_fy = 0, m_tries = 0;
  bit m_cv = 0, m_fv = 0, m_fail = 0;
  int m_next;

  function automatic int lfsr_step(input int l);
    // Multiply by x modulo x^8+x^4+x^3+x^2+1.
    return ((l << 1) & 255) ^ (((l & 128) != 0) ? 'h1D : 0);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_lfsr = 255; m_phase = 0; m_cx = 0; m_cy = 0; m_fx = 0; m_fy = 0;
      m_tries = 0; m_cv = 0; m_fv = 0; m_fail = 0;
    end else begin
      m_next = seed_load ? ((seed_in == 0) ? 255 : int'(seed_in)) : lfsr_step(m_lfsr);
      m_fv = 0;
      m_fail = 0;
      if (m_phase == 0) begin
        if (req) begin m_phase = 1; m_tries = 0; end
      end else if (m_phase == 1) begin
        if ((m_lfsr % (1 << XW)) < GW) begin m_cx = m_lfsr % (1 << XW); m_phase = 2; end
      end else if (m_phase == 2) begin
        if ((m_lfsr >> (8 - YW)) < GH) begin m_cy = m_lfsr >> (8 - YW); m_cv = 1; m_phase = 3; end
      end else if (chk_done) begin
        m_cv = 0;
        m_tries++;
        if (!chk_hit) begin
          m_fx = m_cx; m_fy = m_cy; m_fv = 1; m_phase = 0;
        end else if (m_tries >= MT) begin
          m_fail = 1; m_phase = 0;
        end else begin
          m_phase = 1;
        end
      end
      m_lfsr = m_next;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [33:0] act_v, exp_v;
  logic [XW-1:0] e_cx, e_fx;
  logic [YW-1:0] e_cy, e_fy;
  logic [7:0] e_l;

  always @(negedge clk) begin
    e_cx = m_cx[XW-1:0]; e_fx = m_fx[XW-1:0];
    e_cy = m_cy[YW-1:0]; e_fy = m_fy[YW-1:0];
    e_l  = m_lfsr[7:0];
    act_v = {busy, chk_valid, chk_x, chk_y, food_valid, food_x, food_y, fail, rand_o};
    exp_v = {(m_phase != 0), m_cv, e_cx, e_cy, m_fv, e_fx, e_fy, m_fail, e_l};
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL model_cycle t=%0t got busy/cv/cx/cy/fv/fx/fy/fail/rand=%b/%b/%0d/%0d/%b/%0d/%0d/%b/%h expected %b/%b/%0d/%0d/%b/%0d/%0d/%b/%h",
               $time, busy, chk_valid, chk_x, chk_y, food_valid, food_x, food_y, fail, rand_o,
               (m_phase != 0), m_cv, e_cx, e_cy, m_fv, e_fx, e_fy, m_fail, e_l);
    end
    if (food_valid) n_food++;
    if (fail) n_fail++;
    if (chk_valid && !prev_cv) n_txn++;
    prev_cv = chk_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int fx0, fy0, food0, fail0, txn0;
  logic [XW-1:0] cx_hold;
  logic [YW-1:0] cy_hold;
  bit seen;

  initial begin
    #1 rst = 1'b0;
    repeat (3) step();
    chk("reset_busy", busy, 0);
    chk("reset_chk_valid", chk_valid, 0);
    chk("reset_food_xy", {food_x, food_y}, 0);
    chk("reset_rand", rand_o, 8'hFF);
    rst = 1'b1;

    // LFSR sequence right after reset release
    @(negedge clk); chk("lfsr_0", rand_o, 8'hFF);
    @(negedge clk); chk("lfsr_1", rand_o, 8'hE3);
    @(negedge clk); chk("lfsr_2", rand_o, 8'hDB);

    // Seeding, including the zero-seed substitution
    step();
    seed_load = 1; seed_in = 8'h00;
    step(); chk("seed_zero", rand_o, 8'hFF);
    seed_in = 8'h5A;
    step(); chk("seed_5a", rand_o, 8'h5A);
    seed_load = 0;

    // Free cell answered on the first CHECK cycle
    food0 = n_food;
    chk_done = 1; chk_hit = 0;
    req = 1; step(); req = 0;
    seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      if (food_valid) seen = 1; else step();
    end
    chk("t3_food_seen", seen, 1);
    chk("t3_x_range", (food_x < GW), 1);
    chk("t3_y_range", (food_y < GH), 1);
    chk("t3_x_eq_chk", food_x, chk_x);
    chk("t3_y_eq_chk", food_y, chk_y);
    step(); chk("t3_busy_low", busy, 0);
    repeat (2) step();
    chk("t3_food_once", n_food - food0, 1);

    // Every candidate occupied: MT transactions then one fail
    fx0 = food_x; fy0 = food_y; food0 = n_food; fail0 = n_fail; txn0 = n_txn;
    chk_done = 1; chk_hit = 1;
    req = 1; step(); req = 0;
    seen = 0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      if (fail) seen = 1; else step();
    end
    chk("t4_fail_seen", seen, 1);
    repeat (3) step();
    chk("t4_txn_count", n_txn - txn0, MT);
    chk("t4_fail_once", n_fail - fail0, 1);
    chk("t4_no_food", n_food - food0, 0);
    chk("t4_food_kept", {food_x, food_y}, {fx0[XW-1:0], fy0[YW-1:0]});

    // Slow checker with an extra req in the middle
    food0 = n_food; txn0 = n_txn;
    chk_done = 0; chk_hit = 0;
    req = 1; step(); req = 0;
    seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      if (chk_valid) seen = 1; else step();
    end
    chk("t5_chk_valid_seen", seen, 1);
    cx_hold = chk_x; cy_hold = chk_y;
    for (int i = 0; i < 5; i++) begin
      req = (i == 2);
      step();
      chk("t5_hold_xy", {chk_valid, chk_x, chk_y}, {1'b1, cx_hold, cy_hold});
    end
    req = 0; chk_done = 1;
    step(); chk_done = 0;
    chk("t5_food_pulse", food_valid, 1);
    chk("t5_food_xy", {food_x, food_y}, {cx_hold, cy_hold});
    repeat (4) step();
    chk("t5_food_once", n_food - food0, 1);
    chk("t5_req_ignored", busy, 0);

    // Asynchronous reset while a check is outstanding
    chk_done = 0;
    req = 1; step(); req = 0;
    seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      if (chk_valid) seen = 1; else step();
    end
    chk("t6_chk_valid_seen", seen, 1);
    #1 rst = 0;
    #1;
    chk("t6_async_cv", chk_valid, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_lfsr", rand_o, 8'hFF);
    step(); step();
    rst = 1;
    food0 = n_food; fail0 = n_fail;
    chk_done = 1; chk_hit = 0;
    repeat (20) step();
    chk("t6_no_pulse", (n_food - food0) + (n_fail - fail0), 0);

    // Randomized traffic; the per-cycle compare does the checking
    for (int i = 0; i < 3000; i++) begin
      req = ($urandom_range(0, 7) == 0);
      chk_done = ($urandom_range(0, 2) == 0);
      chk_hit = $urandom_range(0, 1);
      seed_load = ($urandom_range(0, 49) == 0);
      seed_in = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      step();
    end
    req = 0; seed_load = 0; chk_done = 1;
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
